instr_fetch_unit: RTL and testbench

//  Fetch stage directly downstream of the PC register / next-PC logic (PC+4 or PC+branch offset).

---
 rtl/instr_fetch_unit_pkg.sv | 15 +
 rtl/instr_fetch_unit_fifo.sv | 54 +++++
 rtl/instr_fetch_unit.sv | 106 ++++++++++
 tb/tb_instr_fetch_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: widths, the NOP used for
// misalign markers, and the fetch FSM state encoding.
package instr_fetch_unit_pkg;

  localparam int DEFAULT_XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Small synchronous instruction buffer with flush; the head is read straight
// from register storage so decode sees registered values.
module fetch_fifo #(
  parameter int WIDTH = 97,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  assign head = mem[rd_ptr];

  // A flush restarts the buffer at slot 0, keeping a same-cycle push as the only entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      if (push) begin
        mem[0] <= push_data;
        wr_ptr <= AW'(1);
        count  <= CW'(1);
      end else begin
        wr_ptr <= '0;
        count  <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns fetch_pc, runs the imem req/gnt/rvalid handshake with a
// single-credit scheme, and buffers PC-tagged instructions toward decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int               XLEN       = DEFAULT_XLEN,
  parameter int               FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0]  RESET_PC   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [ILEN-1:0]  imem_rdata,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [XLEN-1:0]  if_pc,
  output logic [ILEN-1:0]  if_instr,
  output logic             if_misalign
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = XLEN + ILEN + 1;

  fetch_state_e     state;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  req_pc;
  logic             drop;
  logic             running;
  logic [CW-1:0]    count;
  logic             granted;
  logic             pending;
  logic             misalign_tgt;
  logic             push;
  logic             pop;
  logic [EW-1:0]    push_data;
  logic [EW-1:0]    head;

  // In FETCH nothing is outstanding, so count alone decides whether a slot is free.
  assign imem_req     = running && (state == FETCH) && (count < CW'(FIFO_DEPTH));
  assign imem_addr    = fetch_pc;
  assign granted      = imem_req && imem_gnt;
  assign misalign_tgt = redirect_pc[1:0] != 2'b00;
  assign pending      = granted ||
                        (((state == WAIT) || ((state == HALT) && drop)) && !imem_rvalid);

  assign push      = redirect_valid ? misalign_tgt : ((state == WAIT) && imem_rvalid && !drop);
  assign push_data = redirect_valid ? {redirect_pc, 1'b1, NOP_INSTR} : {req_pc, 1'b0, imem_rdata};
  assign pop       = if_valid && if_ready && !redirect_valid;

  assign if_valid = count != '0;
  assign {if_pc, if_misalign, if_instr} = head;

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // A redirect overrides all FSM activity; any in-flight response becomes a drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      drop     <= 1'b0;
      running  <= 1'b0;
    end else begin
      running <= 1'b1;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        drop     <= pending;
        if (misalign_tgt) state <= HALT;
        else if (pending) state <= WAIT;
        else              state <= FETCH;
      end else begin
        case (state)
          FETCH: if (granted) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + XLEN'(4);
            state    <= WAIT;
          end
          WAIT: if (imem_rvalid) begin
            drop  <= 1'b0;
            state <= FETCH;
          end
          HALT: if (imem_rvalid) drop <= 1'b0;
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a responding imem model feeds a
// scoreboard of expected decode entries, checked as they leave the FIFO.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [63:0] pc;
    logic        mis;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_misalign;

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_misalign    (if_misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  int vectors = 0;
  int miscompares = 0;

  ent_t        sb[$];
  logic [63:0] exp_pc = '0;
  bit          armed = 0;
  bit          live = 0;
  bit          halted = 0;
  bit          mem_pend = 0;
  bit          mem_drop = 0;
  int          mem_wait = 0;
  logic [63:0] mem_addr = '0;
  int          rsp_lat = 1;
  bit          drv_reset = 1;
  bit          drv_ready = 0;
  bit          drv_redir = 0;
  logic [63:0] drv_tgt = '0;
  bit          drv_stray = 0;
  int          grants = 0;
  int          pops = 0;
  int          cyc = 0;
  int          last_pop_cyc = 0;
  logic [63:0] last_pop_pc = '0;
  logic        last_pop_mis = 1'b0;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return 32'hA000_0000 ^ a[31:0] ^ {a[47:32], 16'h0};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock: check the DUT against the model, drive inputs, advance the model.
  task automatic applyStimulus();
    logic        exp_req;
    logic        rsp;
    logic        got;
    logic [63:0] rsp_addr;
    ent_t        e;
    if (armed) begin
      exp_req = live && !halted && !mem_pend && (sb.size() < 2);
      checkOutput("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
      checkOutput("if_valid", {63'd0, if_valid}, {63'd0, sb.size() != 0});
      if (imem_req) checkOutput("imem_addr", imem_addr, exp_pc);
    end
    reset          = drv_reset;
    if_ready       = drv_ready;
    redirect_valid = drv_redir;
    redirect_pc    = drv_tgt;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    imem_gnt       = 1'b0;
    if (drv_stray) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else if (mem_pend && !drv_reset) begin
      if (mem_wait == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = instr_of(mem_addr);
      end else begin
        mem_wait--;
      end
    end
    imem_gnt = imem_req && !drv_reset;
    if (drv_reset) begin
      sb.delete();
      live     = 0;
      halted   = 0;
      mem_pend = 0;
      mem_drop = 0;
      exp_pc   = '0;
    end else begin
      rsp      = imem_rvalid && !drv_stray;
      got      = rsp && !mem_drop;
      rsp_addr = mem_addr;
      if (rsp) begin
        mem_pend = 0;
        mem_drop = 0;
      end
      if (imem_gnt) begin
        grants++;
        mem_pend = 1;
        mem_drop = 0;
        mem_addr = imem_addr;
        mem_wait = rsp_lat - 1;
        exp_pc   = exp_pc + 64'd4;
      end
      if (drv_redir) begin
        sb.delete();
        exp_pc = drv_tgt;
        if (mem_pend) mem_drop = 1;
        halted = drv_tgt[1:0] != 2'b00;
        if (halted) begin
          e.pc = drv_tgt; e.mis = 1'b1; e.instr = NOP;
          sb.push_back(e);
        end
      end else begin
        if (if_valid && drv_ready && sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput("if_pc", if_pc, e.pc);
          checkOutput("if_instr", {32'd0, if_instr}, {32'd0, e.instr});
          checkOutput("if_misalign", {63'd0, if_misalign}, {63'd0, e.mis});
          pops++;
          last_pop_pc  = if_pc;
          last_pop_mis = if_misalign;
          last_pop_cyc = cyc;
        end
        if (got) begin
          e.pc = rsp_addr; e.mis = 1'b0; e.instr = imem_rdata;
          sb.push_back(e);
        end
      end
      live = 1;
    end
    @(posedge clk);
    if (drv_reset) armed = 1;
    @(negedge clk);
    cyc++;
  endtask

  task automatic doReset();
    drv_reset = 1;
    drv_redir = 0;
    drv_stray = 0;
    repeat (2) applyStimulus();
    drv_reset = 0;
  endtask

  task automatic doRedirect(input logic [63:0] tgt);
    drv_redir = 1;
    drv_tgt   = tgt;
    applyStimulus();
    drv_redir = 0;
  endtask

  task automatic runUntilPop(input string tag, input int maxc);
    int start;
    int n;
    start = pops;
    n = 0;
    while (pops == start && n < maxc) begin
      applyStimulus();
      n++;
    end
    checkOutput(tag, 64'(pops - start), 64'd1);
  endtask

  initial begin
    int  c0;
    int  g0;
    int  n;
    bit  reached;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;

    $display("[TB] test 1: streaming fetch");
    doReset();
    rsp_lat = 1; drv_ready = 1;
    runUntilPop("t1_wait0", 10);
    checkOutput("t1_pc0", last_pop_pc, 64'h0);
    c0 = last_pop_cyc;
    runUntilPop("t1_wait1", 10);
    checkOutput("t1_pc1", last_pop_pc, 64'h4);
    checkOutput("t1_gap1", 64'(last_pop_cyc - c0), 64'd2);
    c0 = last_pop_cyc;
    runUntilPop("t1_wait2", 10);
    checkOutput("t1_pc2", last_pop_pc, 64'h8);
    checkOutput("t1_gap2", 64'(last_pop_cyc - c0), 64'd2);

    $display("[TB] test 2: decode stalled");
    doReset();
    drv_ready = 0;
    g0 = grants;
    repeat (10) applyStimulus();
    checkOutput("t2_grants", 64'(grants - g0), 64'd2);
    drv_ready = 1;
    runUntilPop("t2_wait0", 5);
    checkOutput("t2_pc0", last_pop_pc, 64'h0);
    runUntilPop("t2_wait1", 5);
    checkOutput("t2_pc1", last_pop_pc, 64'h4);

    $display("[TB] test 3: redirect with request outstanding");
    doReset();
    rsp_lat = 3; drv_ready = 1;
    n = 0;
    while (!(mem_pend && mem_addr == 64'h8) && n < 40) begin applyStimulus(); n++; end
    reached = mem_pend && mem_addr == 64'h8;
    checkOutput("t3_reach", {63'd0, reached}, 64'd1);
    applyStimulus();
    doRedirect(64'h100);
    checkOutput("t3_flush", {63'd0, if_valid}, 64'd0);
    runUntilPop("t3_wait", 20);
    checkOutput("t3_pc", last_pop_pc, 64'h100);

    $display("[TB] test 4: redirect with grant and pop");
    doReset();
    rsp_lat = 1; drv_ready = 0;
    n = 0;
    while (!(imem_req && imem_addr == 64'h4 && if_valid) && n < 20) begin applyStimulus(); n++; end
    reached = imem_req && imem_addr == 64'h4 && if_valid;
    checkOutput("t4_reach", {63'd0, reached}, 64'd1);
    drv_ready = 1;
    doRedirect(64'h300);
    runUntilPop("t4_wait", 20);
    checkOutput("t4_pc", last_pop_pc, 64'h300);

    $display("[TB] test 4b: redirect with rvalid");
    n = 0;
    while (!(mem_pend && mem_wait == 0) && n < 20) begin applyStimulus(); n++; end
    reached = mem_pend && mem_wait == 0;
    checkOutput("t4b_reach", {63'd0, reached}, 64'd1);
    doRedirect(64'h400);
    runUntilPop("t4b_wait", 20);
    checkOutput("t4b_pc", last_pop_pc, 64'h400);

    $display("[TB] test 5: misaligned target");
    drv_ready = 0;
    doRedirect(64'h102);
    g0 = grants;
    repeat (6) applyStimulus();
    drv_ready = 1;
    runUntilPop("t5_wait", 5);
    checkOutput("t5_pc", last_pop_pc, 64'h102);
    checkOutput("t5_mis", {63'd0, last_pop_mis}, 64'd1);
    repeat (4) applyStimulus();
    checkOutput("t5_no_req", 64'(grants - g0), 64'd0);
    doRedirect(64'h200);
    runUntilPop("t5_resume", 20);
    checkOutput("t5_resume_pc", last_pop_pc, 64'h200);

    $display("[TB] test wrap: fetch_pc rollover");
    doRedirect(64'hFFFF_FFFF_FFFF_FFFC);
    runUntilPop("wrap_wait0", 20);
    checkOutput("wrap_pc0", last_pop_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    runUntilPop("wrap_wait1", 20);
    checkOutput("wrap_pc1", last_pop_pc, 64'h0);

    $display("[TB] test 6: reset during WAIT");
    rsp_lat = 3;
    n = 0;
    while (!(mem_pend && !mem_drop) && n < 20) begin applyStimulus(); n++; end
    reached = mem_pend && !mem_drop;
    checkOutput("t6_reach", {63'd0, reached}, 64'd1);
    doReset();
    checkOutput("t6_req", {63'd0, imem_req}, 64'd0);
    checkOutput("t6_addr", imem_addr, 64'h0);
    checkOutput("t6_valid", {63'd0, if_valid}, 64'd0);
    checkOutput("t6_if_pc", if_pc, 64'h0);
    checkOutput("t6_if_instr", {32'd0, if_instr}, 64'h0);
    checkOutput("t6_if_mis", {63'd0, if_misalign}, 64'd0);
    drv_stray = 1;
    applyStimulus();
    drv_stray = 0;
    runUntilPop("t6_wait", 20);
    checkOutput("t6_pc", last_pop_pc, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
